// File: rtl/mul_ctrl_pkg.sv
// Shared types and constants for the UART-driven multiplier sequencer.
// Holds the FSM state encoding, the byte/product widths and the counter width helper.
package mul_ctrl_pkg;

   localparam int          BYTE_W          = 8;
   localparam int          PROD_W          = 16;
   localparam logic [23:0] DEFAULT_TIMEOUT = 24'd1000000;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_GET_B,
      ST_MUL,
      ST_SEND1,
      ST_WAIT1_BUSY,
      ST_WAIT1_DONE,
      ST_SEND2,
      ST_WAIT2_BUSY,
      ST_WAIT2_DONE
   } mul_ctrl_state_t;

   // Bits needed to count 0 .. n-1, never less than one.
   function automatic int cnt_width(input logic [23:0] n);
      return (n > 24'd2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mul_ctrl_timeout.sv
// Loadable up-counter with clear that flags the terminal count TIMEOUT_CYCLES-1.
// Counting stops at the terminal value so the flag stays asserted until cleared.
module mul_ctrl_timeout
   import mul_ctrl_pkg::*;
#(
   parameter logic [23:0] TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
   localparam int         CNT_W          = cnt_width(TIMEOUT_CYCLES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic             tc
);

   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 24'd1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && !tc) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/mul_uart_seq_ctrl.sv
// Collects two operand bytes from the UART, captures the 8x8 product and
// returns it as two bytes over the transmitter's start/ready handshake.
module mul_uart_seq_ctrl
   import mul_ctrl_pkg::*;
#(
   parameter logic [23:0] TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
   parameter logic        MSB_FIRST      = 1'b1
) (
   input  logic              clk_int,
   input  logic              reset,
   input  logic [BYTE_W-1:0] rx_data,
   input  logic              rx_valid,
   input  logic              tx_ready,
   output logic              tx_start,
   output logic [BYTE_W-1:0] tx_data,
   output logic [BYTE_W-1:0] mul_a,
   output logic [BYTE_W-1:0] mul_b,
   input  logic [PROD_W-1:0] mul_p,
   output logic              busy,
   output logic              err_timeout,
   output logic              err_overrun,
   input  logic              err_clear
);

   mul_ctrl_state_t   state, state_d;
   logic [PROD_W-1:0] prod;
   logic [BYTE_W-1:0] byte_d;
   logic              fire, load_a, load_b, load_p;
   logic              cnt_clr, cnt_en, tc, set_to, set_ov;

   function automatic logic [BYTE_W-1:0] first_byte(input logic [PROD_W-1:0] p);
      return MSB_FIRST ? p[PROD_W-1:BYTE_W] : p[BYTE_W-1:0];
   endfunction

   function automatic logic [BYTE_W-1:0] second_byte(input logic [PROD_W-1:0] p);
      return MSB_FIRST ? p[BYTE_W-1:0] : p[PROD_W-1:BYTE_W];
   endfunction

   mul_ctrl_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk      (clk_int),
      .rst      (reset),
      .clr      (cnt_clr),
      .load     (1'b0),
      .load_val ('0),
      .en       (cnt_en),
      .tc       (tc)
   );

   // tx_start is registered, so the launch decision is made one state early:
   // MUL fires the first byte straight from mul_p, which prod captures on the same edge.
   always_comb begin
      state_d = state;
      fire    = 1'b0;
      byte_d  = '0;
      load_a  = 1'b0;
      load_b  = 1'b0;
      load_p  = 1'b0;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      set_to  = 1'b0;
      case (state)
         ST_IDLE: if (rx_valid) begin
            load_a  = 1'b1;
            cnt_clr = 1'b1;
            state_d = ST_GET_B;
         end
         ST_GET_B: begin
            if (rx_valid) begin
               load_b  = 1'b1;
               state_d = ST_MUL;
            end else if (tc) begin
               set_to  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_en = 1'b1;
            end
         end
         ST_MUL: begin
            load_p  = 1'b1;
            state_d = ST_SEND1;
            fire    = tx_ready;
            byte_d  = first_byte(mul_p);
         end
         ST_SEND1: begin
            if (tx_start) begin
               state_d = ST_WAIT1_BUSY;
            end else begin
               fire   = tx_ready;
               byte_d = first_byte(prod);
            end
         end
         ST_WAIT1_BUSY: if (!tx_ready) state_d = ST_WAIT1_DONE;
         ST_WAIT1_DONE: if (tx_ready) begin
            state_d = ST_SEND2;
            fire    = 1'b1;
            byte_d  = second_byte(prod);
         end
         ST_SEND2: begin
            if (tx_start) begin
               state_d = ST_WAIT2_BUSY;
            end else begin
               fire   = tx_ready;
               byte_d = second_byte(prod);
            end
         end
         ST_WAIT2_BUSY: if (!tx_ready) state_d = ST_WAIT2_DONE;
         ST_WAIT2_DONE: if (tx_ready) state_d = ST_IDLE;
         default:       state_d = ST_IDLE;
      endcase
   end

   assign set_ov = rx_valid && !(state inside {ST_IDLE, ST_GET_B});
   assign busy   = (state != ST_IDLE);

   always_ff @(posedge clk_int) begin
      if (reset) begin
         state       <= ST_IDLE;
         tx_start    <= 1'b0;
         err_timeout <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         state       <= state_d;
         tx_start    <= fire;
         err_timeout <= set_to | (err_timeout & ~err_clear);
         err_overrun <= set_ov | (err_overrun & ~err_clear);
      end
   end

   always_ff @(posedge clk_int) begin
      if (reset) begin
         tx_data <= '0;
         mul_a   <= '0;
         mul_b   <= '0;
         prod    <= '0;
      end else begin
         if (fire)   tx_data <= byte_d;
         if (load_a) mul_a   <= rx_data;
         if (load_b) mul_b   <= rx_data;
         if (load_p) prod    <= mul_p;
      end
   end

endmodule

// File: tb/tb_mul_uart_seq_ctrl.sv
// Bench for mul_uart_seq_ctrl: two instances (MSB-first and LSB-first) share stimulus,
// a simple transmitter model answers tx_start, and the bench multiplies the operands itself.
module tb_mul_uart_seq_ctrl;

   typedef struct packed {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] p;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset, rx_valid, tx_ready, err_clear;
   logic [7:0]  rx_data;
   logic        tx_start0, tx_start1, busy0, busy1;
   logic [7:0]  tx_data0, tx_data1, mul_a0, mul_b0, mul_a1, mul_b1;
   logic [15:0] mul_p0, mul_p1;
   logic        err_timeout0, err_timeout1, err_overrun0, err_overrun1;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          n0 = 0;
   int          n1 = 0;
   int          first_cyc = 0;
   int          txcnt = 0;
   logic        force_low = 1'b0;
   logic [7:0]  b0 [4];
   logic [7:0]  b1 [4];
   vec_t        vecs [5];

   always #5 clk = ~clk;

   assign mul_p0 = {8'h00, mul_a0} * {8'h00, mul_b0};
   assign mul_p1 = {8'h00, mul_a1} * {8'h00, mul_b1};

   mul_uart_seq_ctrl #(.TIMEOUT_CYCLES(24'd16), .MSB_FIRST(1'b1)) dut0 (
      .clk_int(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_ready(tx_ready), .tx_start(tx_start0), .tx_data(tx_data0),
      .mul_a(mul_a0), .mul_b(mul_b0), .mul_p(mul_p0), .busy(busy0),
      .err_timeout(err_timeout0), .err_overrun(err_overrun0), .err_clear(err_clear)
   );

   mul_uart_seq_ctrl #(.TIMEOUT_CYCLES(24'd16), .MSB_FIRST(1'b0)) dut1 (
      .clk_int(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_ready(tx_ready), .tx_start(tx_start1), .tx_data(tx_data1),
      .mul_a(mul_a1), .mul_b(mul_b1), .mul_p(mul_p1), .busy(busy1),
      .err_timeout(err_timeout1), .err_overrun(err_overrun1), .err_clear(err_clear)
   );

   // Mid-cycle monitor: logs every launched byte and the cycle of the first one.
   initial forever begin
      @(negedge clk);
      cyc++;
      if (tx_start0) begin
         if (n0 == 0) first_cyc = cyc;
         if (n0 < 4) b0[n0] = tx_data0;
         n0++;
      end
      if (tx_start1) begin
         if (n1 < 4) b1[n1] = tx_data1;
         n1++;
      end
   end

   // Transmitter model: goes busy for three cycles after each start pulse.
   initial begin
      tx_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         if (force_low) begin
            tx_ready = 1'b0;
         end else if (tx_start0) begin
            tx_ready = 1'b0;
            txcnt    = 3;
         end else if (txcnt > 0) begin
            txcnt--;
            if (txcnt == 0) tx_ready = 1'b1;
         end else begin
            tx_ready = 1'b1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] d);
      rx_data  = d;
      rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
   endtask

   task automatic clear_log();
      n0 = 0;
      n1 = 0;
      first_cyc = 0;
      for (int i = 0; i < 4; i++) begin
         b0[i] = 8'hxx;
         b1[i] = 8'hxx;
      end
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      while (busy0 && k < 60) begin
         step();
         k++;
      end
      chk($sformatf("%s idle", name), {31'd0, busy0}, 32'd0);
   endtask

   task automatic wait_pulse(input string name);
      int k = 0;
      while (n0 < 1 && k < 30) begin
         step();
         k++;
      end
      chk($sformatf("%s first pulse", name), n0, 1);
   endtask

   task automatic run_frame(input vec_t v, input string name);
      int bc;
      clear_log();
      send(v.a);
      send(v.b);
      bc = cyc;
      wait_idle(name);
      chk($sformatf("%s pulses msb", name), n0, 2);
      chk($sformatf("%s pulses lsb", name), n1, 2);
      chk($sformatf("%s msb byte1", name), {24'd0, b0[0]}, {24'd0, v.p[15:8]});
      chk($sformatf("%s msb byte2", name), {24'd0, b0[1]}, {24'd0, v.p[7:0]});
      chk($sformatf("%s lsb byte1", name), {24'd0, b1[0]}, {24'd0, v.p[7:0]});
      chk($sformatf("%s lsb byte2", name), {24'd0, b1[1]}, {24'd0, v.p[15:8]});
      chk($sformatf("%s latency", name), first_cyc - bc, 2);
      chk($sformatf("%s errors", name), {30'd0, err_timeout0, err_overrun0}, 32'd0);
   endtask

   initial begin
      vecs[0] = '{a: 8'h0C, b: 8'h0D, p: 16'h009C};
      vecs[1] = '{a: 8'hFF, b: 8'hFF, p: 16'hFE01};
      vecs[2] = '{a: 8'h03, b: 8'h07, p: 16'h0015};
      vecs[3] = '{a: 8'h80, b: 8'h02, p: 16'h0100};
      vecs[4] = '{a: 8'h0F, b: 8'h11, p: 16'h00FF};

      reset     = 1'b1;
      rx_valid  = 1'b0;
      rx_data   = 8'h00;
      err_clear = 1'b0;
      step();
      step();
      chk("rst tx_start", {31'd0, tx_start0}, 32'd0);
      chk("rst tx_data", {24'd0, tx_data0}, 32'd0);
      chk("rst mul_a", {24'd0, mul_a0}, 32'd0);
      chk("rst mul_b", {24'd0, mul_b0}, 32'd0);
      chk("rst busy", {31'd0, busy0}, 32'd0);
      chk("rst errors", {30'd0, err_timeout0, err_overrun0}, 32'd0);
      reset = 1'b0;
      step();
      chk("post-rst tx_start", {31'd0, tx_start0}, 32'd0);

      for (int i = 0; i < 5; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

      // Operand B never arrives.
      clear_log();
      send(8'h05);
      repeat (15) step();
      chk("to early flag", {31'd0, err_timeout0}, 32'd0);
      chk("to early busy", {31'd0, busy0}, 32'd1);
      step();
      chk("to flag", {31'd0, err_timeout0}, 32'd1);
      chk("to busy", {31'd0, busy0}, 32'd0);
      chk("to no start", n0, 0);
      chk("to mul_a kept", {24'd0, mul_a0}, 32'h05);
      err_clear = 1'b1;
      step();
      err_clear = 1'b0;
      chk("to cleared", {31'd0, err_timeout0}, 32'd0);

      // B arrives in the terminal-count cycle.
      clear_log();
      send(8'h21);
      repeat (15) step();
      send(8'h03);
      chk("tc accept flag", {31'd0, err_timeout0}, 32'd0);
      chk("tc accept busy", {31'd0, busy0}, 32'd1);
      wait_idle("tc");
      chk("tc pulses", n0, 2);
      chk("tc byte1", {24'd0, b0[0]}, 32'h00);
      chk("tc byte2", {24'd0, b0[1]}, 32'h63);
      chk("tc flag end", {31'd0, err_timeout0}, 32'd0);

      // Transmitter stalled, then a stray byte while waiting for the first byte to finish.
      force_low = 1'b1;
      step();
      step();
      clear_log();
      send(8'h12);
      send(8'h34);
      repeat (50) step();
      chk("stall no start", n0, 0);
      chk("stall busy", {31'd0, busy0}, 32'd1);
      force_low = 1'b0;
      wait_pulse("stall");
      step();
      rx_data   = 8'h77;
      rx_valid  = 1'b1;
      err_clear = 1'b1;
      step();
      rx_valid  = 1'b0;
      err_clear = 1'b0;
      chk("overrun set wins", {31'd0, err_overrun0}, 32'd1);
      wait_idle("stall");
      chk("stall pulses", n0, 2);
      chk("stall byte1", {24'd0, b0[0]}, 32'h03);
      chk("stall byte2", {24'd0, b0[1]}, 32'hA8);
      chk("stall lsb byte1", {24'd0, b1[0]}, 32'hA8);
      chk("stall mul_b kept", {24'd0, mul_b0}, 32'h34);

      // Reset in WAIT1_BUSY aborts the frame.
      clear_log();
      send(8'h44);
      send(8'h55);
      wait_pulse("abort");
      chk("abort busy", {31'd0, busy0}, 32'd1);
      chk("overrun sticky", {31'd0, err_overrun0}, 32'd1);
      reset = 1'b1;
      step();
      chk("abort tx_start", {31'd0, tx_start0}, 32'd0);
      chk("abort tx_data", {24'd0, tx_data0}, 32'd0);
      chk("abort mul_a", {24'd0, mul_a0}, 32'd0);
      chk("abort mul_b", {24'd0, mul_b0}, 32'd0);
      chk("abort busy low", {31'd0, busy0}, 32'd0);
      chk("abort errors", {30'd0, err_timeout0, err_overrun0}, 32'd0);
      reset = 1'b0;
      step();
      chk("abort no start", {31'd0, tx_start0}, 32'd0);
      chk("abort pulse count", n0, 1);
      run_frame('{a: 8'h03, b: 8'h07, p: 16'h0015}, "fresh");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
